// File: rtl/stream_mux_pkg.sv
// Purpose: shared constants and types for the stream_mux_rr block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: mode encodings, output-register state enum, beat counter width.
// Optional feature macro: STREAM_MUX_BEAT_CNT_EN (beat counter in stream_mux_rr).
package stream_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_t;

  localparam int BEAT_CNT_W = 16;

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Purpose: round-robin arbiter over NUM_CH requests; owns the last_grant pointer.
// Latency: grant is combinational from req and last_grant; pointer updates on the next edge.
// Backpressure: none internally; caller asserts advance only when the grant is consumed.
// Ports:
//   clk, rst_n    clock, async active-low reset (pointer resets to NUM_CH-1)
//   req           per-channel request
//   advance       grant was consumed this cycle; pointer moves to gnt_idx
//   last_grant    current pointer (most recently served channel)
//   gnt, gnt_idx  one-hot grant and its index; gnt_vld high when any request won
module rr_arbiter #(
  parameter  int NUM_CH = 4,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req,
  input  logic              advance,
  output logic [CH_W-1:0]   last_grant,
  output logic [NUM_CH-1:0] gnt,
  output logic [CH_W-1:0]   gnt_idx,
  output logic              gnt_vld
);

  localparam logic [CH_W-1:0] PTR_RST = CH_W'(NUM_CH - 1);

  // Search starts one past the last served channel and wraps, so the channel
  // just served has the lowest priority next time.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int i = 1; i <= NUM_CH; i++) begin
      if (!gnt_vld && req[(int'(last_grant) + i) % NUM_CH]) begin
        gnt_vld = 1'b1;
        gnt_idx = CH_W'((int'(last_grant) + i) % NUM_CH);
        gnt[(int'(last_grant) + i) % NUM_CH] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= PTR_RST;
    end else if (advance && gnt_vld) begin
      last_grant <= gnt_idx;
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// Purpose: NUM_CH:1 valid/ready stream mux, fixed-select or round-robin, registered output.
// Latency: 1 cycle from input transfer to out_*; 1 beat/cycle sustained while out_ready=1.
// Backpressure: while the output register is FULL and out_ready=0 all in_ready are 0 and out_* hold.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   mode, sel           0 = fixed channel sel, 1 = round-robin
//   in_valid/in_data    per-channel streams, channel k at in_data[k*WIDTH +: WIDTH]
//   in_ready            one-hot or zero, combinational from in_valid/sel/mode/state/out_ready
//   out_valid/out_data/out_ch/out_ready  registered output stream and its source channel
//   beat_cnt            saturating count of output handshakes (only with STREAM_MUX_BEAT_CNT_EN)
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int NUM_CH = 4,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mode,
  input  logic [CH_W-1:0]         sel,
  input  logic [NUM_CH-1:0]       in_valid,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]       in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [CH_W-1:0]         out_ch,
`ifdef STREAM_MUX_BEAT_CNT_EN
  output logic [BEAT_CNT_W-1:0]   beat_cnt,
`endif
  input  logic                    out_ready
);

  out_state_t state;

  logic [NUM_CH-1:0] rr_gnt;
  logic [CH_W-1:0]   rr_idx;
  logic              rr_vld;
  logic [CH_W-1:0]   last_grant;

  logic [NUM_CH-1:0] fix_gnt;
  logic              fix_vld;

  logic [NUM_CH-1:0] gnt;
  logic [CH_W-1:0]   gnt_idx;
  logic              gnt_vld;
  logic [WIDTH-1:0]  gnt_data;

  logic load_en;
  logic xfer;
  logic rr_advance;

  // Pointer only moves on a round-robin transfer; fixed-mode traffic leaves it alone.
  assign rr_advance = xfer && (mode == MODE_RR);

  rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (in_valid),
    .advance    (rr_advance),
    .last_grant (last_grant),
    .gnt        (rr_gnt),
    .gnt_idx    (rr_idx),
    .gnt_vld    (rr_vld)
  );

  // Fixed select: compare against each legal index, so a sel value at or
  // above NUM_CH (possible when NUM_CH is not a power of two) never grants.
  always_comb begin
    fix_gnt = '0;
    fix_vld = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (sel == CH_W'(k) && in_valid[k]) begin
        fix_gnt[k] = 1'b1;
        fix_vld    = 1'b1;
      end
    end
  end

  always_comb begin
    if (mode == MODE_RR) begin
      gnt     = rr_gnt;
      gnt_idx = rr_idx;
      gnt_vld = rr_vld;
    end else begin
      gnt     = fix_gnt;
      gnt_idx = sel;
      gnt_vld = fix_vld;
    end
  end

  // AND-OR data select driven by the one-hot grant.
  always_comb begin
    gnt_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (gnt[k]) begin
        gnt_data = gnt_data | in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  // Register may load when empty, or when its current beat leaves this cycle.
  assign load_en  = (state == EMPTY) || out_ready;
  assign in_ready = load_en ? gnt : '0;
  assign xfer     = load_en && gnt_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (xfer) begin
            state     <= FULL;
            out_valid <= 1'b1;
            out_data  <= gnt_data;
            out_ch    <= gnt_idx;
          end
        end
        FULL: begin
          if (xfer) begin
            // Replace in place: consumer takes the old beat as the new one lands.
            out_data <= gnt_data;
            out_ch   <= gnt_idx;
          end else if (out_ready) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef STREAM_MUX_BEAT_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
    end else if (out_valid && out_ready && (beat_cnt != {BEAT_CNT_W{1'b1}})) begin
      beat_cnt <= beat_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_stream_mux_rr.sv
// Purpose: self-checking bench for stream_mux_rr with a queue-based scoreboard.
// Latency: model predicts each transfer at the negedge before the edge that performs it.
// Backpressure: exercised directed (hold for 5 cycles) and randomly via out_ready.
module tb_stream_mux_rr;

  localparam int W   = 8;
  localparam int NCH = 4;
  localparam int CW  = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           mode = 1'b0;
  logic [CW-1:0]  sel = '0;
  logic [NCH-1:0] in_valid = '0;
  logic [NCH*W-1:0] in_data = '0;
  logic [NCH-1:0] in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [CW-1:0]  out_ch;
  logic           out_ready = 1'b0;
`ifdef STREAM_MUX_BEAT_CNT_EN
  logic [15:0]    beat_cnt;
`endif

  // Second instance with a non-power-of-two channel count for out-of-range sel.
  logic [2:0]     sel2 = 3'd0;
  logic [4:0]     in_valid2 = 5'b11111;
  logic [39:0]    in_data2 = '0;
  logic [4:0]     in_ready2;
  logic           out_valid2;
  logic [W-1:0]   out_data2;
  logic [2:0]     out_ch2;
`ifdef STREAM_MUX_BEAT_CNT_EN
  logic [15:0]    beat_cnt2;
`endif

  always #5 clk = ~clk;

  stream_mux_rr #(.WIDTH(W), .NUM_CH(NCH)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
`ifdef STREAM_MUX_BEAT_CNT_EN
    .beat_cnt(beat_cnt),
`endif
    .out_ready(out_ready)
  );

  stream_mux_rr #(.WIDTH(W), .NUM_CH(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .mode(1'b0), .sel(sel2),
    .in_valid(in_valid2), .in_data(in_data2), .in_ready(in_ready2),
    .out_valid(out_valid2), .out_data(out_data2), .out_ch(out_ch2),
`ifdef STREAM_MUX_BEAT_CNT_EN
    .beat_cnt(beat_cnt2),
`endif
    .out_ready(1'b1)
  );

  typedef struct {
    int d;
    int ch;
  } beat_t;

  beat_t sb[$];
  int    seen[$];
  int    n_pass = 0;
  int    n_total = 0;
  bit    m_full = 1'b0;
  int    m_last = NCH - 1;
  int    m_hs = 0;
  int    g;
  bit    m_load;
  int    held_d;

  task automatic check(string nm, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
  endtask

  // Reference grant straight from the selection rules; -1 means no grant.
  function automatic int model_grant(bit m, int s, logic [NCH-1:0] v, int last);
    if (!m) return (s < NCH && v[s]) ? s : -1;
    for (int i = 1; i <= NCH; i++) begin
      if (v[(last + i) % NCH]) return (last + i) % NCH;
    end
    return -1;
  endfunction

  // Model: predicts in_ready and out_valid, pushes expected beats.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      m_full = 1'b0;
      m_last = NCH - 1;
      m_hs   = 0;
    end else begin
      check("out_valid", int'(out_valid), int'(m_full));
      if (m_full && out_ready) m_hs++;
      g      = model_grant(mode, int'(sel), in_valid, m_last);
      m_load = !m_full || out_ready;
      check("in_ready", int'(in_ready), (m_load && g >= 0) ? (1 << g) : 0);
      if (m_load && g >= 0) begin
        sb.push_back('{int'(in_data[g*W +: W]), g});
        m_full = 1'b1;
        if (mode) m_last = g;
      end else if (out_ready) begin
        m_full = 1'b0;
      end
    end
  end

  // Monitor: compares whatever the DUT presents with the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_out", 0, 1);
      end else begin
        check("out_data", int'(out_data), sb[0].d);
        check("out_ch", int'(out_ch), sb[0].ch);
        if (out_ready) begin
          seen.push_back(int'(out_ch));
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rnd_data();
    for (int k = 0; k < NCH; k++) in_data[k*W +: W] = W'($urandom);
  endtask

  task automatic check_reset_outs(string tag);
    check({tag, "_out_valid"}, int'(out_valid), 0);
    check({tag, "_out_data"}, int'(out_data), 0);
    check({tag, "_out_ch"}, int'(out_ch), 0);
  endtask

  initial begin
    repeat (3) cyc();
    check_reset_outs("rst0");
    rst_n = 1'b1;

    // Round-robin, all channels valid: 0,1,2,3,0,1,2,3.
    seen.delete();
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1; rnd_data();
    repeat (8) begin cyc(); rnd_data(); end
    in_valid = '0;
    repeat (2) cyc();
    check("rr_all_len", seen.size(), 8);
    for (int i = 0; i < seen.size() && i < 8; i++) check("rr_all_seq", seen[i], i % NCH);

    // Round-robin with only channels 1 and 3 valid: 1,3,1,3.
    seen.delete();
    in_valid = 4'b1010;
    repeat (4) begin rnd_data(); cyc(); end
    in_valid = '0;
    repeat (2) cyc();
    check("rr_1010_len", seen.size(), 4);
    for (int i = 0; i < seen.size() && i < 4; i++) check("rr_1010_seq", seen[i], (i % 2 == 0) ? 1 : 3);

    // Fixed select of channel 2.
    mode = 1'b0; sel = 2'd2; in_valid = 4'b1111; rnd_data();
    in_data[2*W +: W] = 8'hA5;
    @(negedge clk);
    check("fixed_rdy", int'(in_ready), 4);
    cyc();
    check("fixed_data", int'(out_data), 8'hA5);
    check("fixed_ch", int'(out_ch), 2);
    in_valid = '0;
    repeat (2) cyc();

    // Backpressure: hold a beat for 5 cycles, then resume without a bubble.
    mode = 1'b1; in_valid = 4'b1111; rnd_data();
    cyc();
    out_ready = 1'b0;
    held_d = int'(out_data);
    repeat (5) begin rnd_data(); cyc(); end
    check("hold_data", int'(out_data), held_d);
    check("hold_rdy", int'(in_ready), 0);
    out_ready = 1'b1;
    cyc();
    check("resume_valid", int'(out_valid), 1);
    in_valid = '0;
    repeat (2) cyc();

    // Single beat then drain.
    in_valid = 4'b0001; rnd_data();
    cyc();
    in_valid = '0;
    check("drain_full", int'(out_valid), 1);
    cyc();
    check("drain_empty", int'(out_valid), 0);

    // Random traffic with a mid-stream reset.
    for (int c = 0; c < 600; c++) begin
      mode      = 1'($urandom);
      sel       = CW'($urandom);
      in_valid  = NCH'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      rnd_data();
      if (c == 300) begin
        in_valid = 4'b1111; out_ready = 1'b1;
        cyc();
        rst_n = 1'b0;
        #1;
        check_reset_outs("rst_mid");
        cyc();
        rst_n = 1'b1;
        seen.delete();
        mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        repeat (2) cyc();
        check("rst_first_rr", (seen.size() > 0) ? seen[0] : -1, 0);
      end
      cyc();
    end
    in_valid = '0; out_ready = 1'b1;
    repeat (2) cyc();

    // Out-of-range fixed select on the 5-channel instance never grants.
    sel2 = 3'd5;
    #1;
    check("sel_oor_rdy", int'(in_ready2), 0);
    sel2 = 3'd4;
    #1;
    check("sel_max_rdy", int'(in_ready2), 5'b10000);

`ifdef STREAM_MUX_BEAT_CNT_EN
    @(negedge clk);
    check("beat_cnt", int'(beat_cnt), m_hs);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
